// File: rtl/data_sync_tx_arbiter.sv
// Round-robin arbiter sharing one DATA_SYNC synchronizer among NUM_REQ requesters; all outputs registered.
// GNT/EN one cycle after REQ is sampled; REQ is ignored (held off) while BUSY, EN high HOLD_CYCLES then low GAP_CYCLES.
module data_sync_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 3,
  parameter int GAP_CYCLES = 2,
  localparam int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           REQ,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]           GNT,
  output logic [ID_W-1:0]              GRANT_ID,
  output logic                         BUSY,
  output logic                         EN,
  output logic [BUS_WIDTH-1:0]         UNSYNC_BUS
);

  localparam int HOLD_CYCLES = NUM_STAGES + 1;
  localparam int CNT_MAX     = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [ID_W-1:0]      ptr, ptr_nxt;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic [ID_W-1:0]      id_nxt;
  logic                 busy_nxt;
  logic                 en_nxt;
  logic [BUS_WIDTH-1:0] bus_nxt;

  logic                 found;
  logic [ID_W-1:0]      sel;
  logic [BUS_WIDTH-1:0] sel_dat;
  int                   idx;

  // Scan from the slot after the last winner, wrapping, so priority rotates.
  always_comb begin
    found   = 1'b0;
    sel     = '0;
    sel_dat = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && REQ[idx]) begin
        found   = 1'b1;
        sel     = ID_W'(idx);
        sel_dat = REQ_DATA[idx*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    gnt_nxt   = '0;
    id_nxt    = GRANT_ID;
    busy_nxt  = BUSY;
    en_nxt    = EN;
    bus_nxt   = UNSYNC_BUS;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
          ptr_nxt   = sel;
          gnt_nxt   = NUM_REQ'(1) << sel;
          id_nxt    = sel;
          busy_nxt  = 1'b1;
          en_nxt    = 1'b1;
          bus_nxt   = sel_dat;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          en_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
        en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
      GNT        <= '0;
      GRANT_ID   <= '0;
      BUSY       <= 1'b0;
      EN         <= 1'b0;
      UNSYNC_BUS <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ptr        <= ptr_nxt;
      GNT        <= gnt_nxt;
      GRANT_ID   <= id_nxt;
      BUSY       <= busy_nxt;
      EN         <= en_nxt;
      UNSYNC_BUS <= bus_nxt;
    end
  end

endmodule
